// File: rtl/activity_sequencer.sv
// activity_sequencer
//   Programmable trigger sequencer for up to g_BANKS inverter-chain activity
//   banks. Produces square-wave or LFSR-randomised toggling at a programmable
//   tick rate for a programmable number of ticks, under a start/stop handshake.
//   The schedule is fully deterministic from the latched configuration.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   cfg_mode          : 0 OFF, 1 SQUARE, 2 RANDOM, 3 reserved (OFF)
//   cfg_half_period   : clocks per tick (0 treated as 1)
//   cfg_ticks         : ticks per run (0 = continuous until stop)
//   cfg_bank_mask     : per-bank enable
//   cfg_seed          : LFSR seed (0 replaced by 16'hACE1)
//   start, stop       : level handshakes, sampled in IDLE / RUN respectively
//   busy, done        : run status (busy in RUN+DONE, done one-cycle pulse)
//   activity_trig     : registered trigger per bank
//   tick_count        : ticks elapsed in the current or last run

// One bank's trigger flop. Kept as its own cell so each bank is an
// independent toggle flop next to its activity chain.
module activity_lane (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tog,
  output logic trig
);
  always_ff @(posedge clk) begin
    if (rst || clr) trig <= 1'b0;
    else if (tog)   trig <= ~trig;
  end
endmodule

module activity_sequencer #(
  parameter int g_BANKS = 4,
  parameter int g_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cfg_mode,
  input  logic [g_CNT_W-1:0] cfg_half_period,
  input  logic [g_CNT_W-1:0] cfg_ticks,
  input  logic [g_BANKS-1:0] cfg_bank_mask,
  input  logic [15:0]        cfg_seed,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic [g_BANKS-1:0] activity_trig,
  output logic [g_CNT_W-1:0] tick_count
);

  localparam logic [1:0]  MODE_SQUARE = 2'd1;
  localparam logic [1:0]  MODE_RANDOM = 2'd2;
  localparam logic [15:0] SEED_DFLT   = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Configuration captured at start acceptance; hp already clamped to >=1.
  typedef struct packed {
    logic [1:0]         mode;
    logic [g_CNT_W-1:0] hp;
    logic [g_CNT_W-1:0] ticks;
    logic [g_BANKS-1:0] mask;
  } cfg_t;

  state_t             state, state_nxt;
  cfg_t               cfg_q;
  logic [g_CNT_W-1:0] div_q;
  logic [15:0]        lfsr_q;

  logic               tick;
  logic               clr;
  logic [g_BANKS-1:0] tog;
  logic [g_CNT_W-1:0] hp_m1;
  logic [g_CNT_W-1:0] tc_nxt;
  logic [15:0]        lfsr_nxt;
  logic [g_BANKS-1:0] rnd_bits;

  assign hp_m1    = cfg_q.hp - 1'b1;
  assign tc_nxt   = tick_count + 1'b1;
  // x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0
  assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign rnd_bits = lfsr_q[g_BANKS-1:0];

  // Next state / tick decode. stop takes priority over a coincident tick.
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    clr       = 1'b0;
    tog       = '0;
    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = (cfg_mode == MODE_SQUARE || cfg_mode == MODE_RANDOM) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_DONE;
        end else if (div_q == hp_m1) begin
          tick = 1'b1;
          tog  = cfg_q.mask & ((cfg_q.mode == MODE_SQUARE) ? {g_BANKS{1'b1}} : rnd_bits);
          if (cfg_q.ticks != '0 && tc_nxt == cfg_q.ticks)
            state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        clr       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        clr       = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg_q      <= '0;
      div_q      <= '0;
      lfsr_q     <= SEED_DFLT;
      tick_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      // status flags are registered versions of the state being entered
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_q.mode  <= cfg_mode;
            cfg_q.hp    <= (cfg_half_period == '0) ? {{(g_CNT_W-1){1'b0}}, 1'b1} : cfg_half_period;
            cfg_q.ticks <= cfg_ticks;
            cfg_q.mask  <= cfg_bank_mask;
            div_q       <= '0;
            tick_count  <= '0;
            lfsr_q      <= (cfg_seed == 16'h0) ? SEED_DFLT : cfg_seed;
          end
        end
        S_RUN: begin
          if (!stop) begin
            if (tick) begin
              div_q      <= '0;
              tick_count <= tc_nxt;
              // LFSR only advances on ticks so the pattern is rate-independent
              if (cfg_q.mode == MODE_RANDOM) lfsr_q <= lfsr_nxt;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Per-bank trigger flops; masked banks never receive a toggle so stay 0.
  for (genvar b = 0; b < g_BANKS; b++) begin : g_lane
    activity_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tog  (tog[b]),
      .trig (activity_trig[b])
    );
  end

endmodule
